id_decode_stage: RTL and testbench
==================================

# id_decode_stage

Parametrised instruction-decode pipeline stage for the MIPS pipelined processor. It holds the IF/ID pipeline register and decodes the held instruction into register indices, shift amount, function code, an extended immediate, the jump target field and a type class. It detects load-use hazards against the EX stage and stalls, inserting a bubble. It also supports branch flush, valid/ready flow control and a saturating stall-cycle counter. It sits between the fetch stage and the ID/EX register.

## Interface
Parameters:
- INSTR_W, 32, instruction and PC width (fixed field positions assume 32)
- DATA_W, 32, width of extended immediate (≥16)
- REG_AW, 5, register index width
- COUNT_W, 16, stall counter width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  fetch presents an instruction
- in_ready  out  1  stage accepts this cycle
- in_instr  in  INSTR_W  fetched instruction
- in_pc  in  INSTR_W  PC of fetched instruction
- flush  in  1  branch/jump taken; discard ID contents and incoming instruction
- ex_mem_read  in  1  instruction in EX is a load
- ex_rt  in  REG_AW  destination of that load
- out_valid  out  1  decoded instruction valid to ID/EX
- out_ready  in  1  ID/EX accepts
- opcode  out  6  Instr[31:26]
- rs, rt, rd, shamt  out  REG_AW  Instr[25:21], [20:16], [15:11], [10:6]
- funct  out  6  Instr[5:0]
- imm_ext  out  DATA_W  extended Instr[15:0]
- jump_addr  out  26  Instr[25:0]
- pc_out  out  INSTR_W  PC of held instruction
- is_r, is_i, is_j  out  1  type class, one-hot when out_valid
- hazard  out  1  load-use stall active this cycle
- stall_cycles  out  COUNT_W  saturating count of hazard cycles

## Operation
- State: id_valid, id_instr, id_pc, stall counter. All decode outputs are combinational from id_instr.
- Class: opcode 0 gives is_r. Opcode 2 or 3 gives is_j. Any other opcode gives is_i.
- Immediate: opcodes 0x0C, 0x0D, 0x0E (andi/ori/xori) zero-extend. All others sign-extend from bit 15.
- Source use:
  - uses_rs = id_valid & ~is_j.
  - uses_rt = id_valid & (is_r | opcode ∈ {0x04, 0x05, 0x2B}).
- Hazard: hazard = ex_mem_read & ex_rt≠0 & ((uses_rs & rs==ex_rt) | (uses_rt & rt==ex_rt)).
- Output valid: out_valid = id_valid & ~hazard & ~flush.
- Input ready: in_ready = ~id_valid | flush | (out_ready & ~hazard).
- Next-state priority:
  1. rst: id_valid=0, id_instr=0, id_pc=0, counter=0.
  2. flush: id_valid←0. An incoming instruction is accepted and dropped.
  3. in_valid & in_ready: capture in_instr/in_pc, id_valid←1.
  4. out_valid & out_ready: id_valid←0.
  5. Otherwise hold.
- Counter: increments when hazard=1 and flush=0. It saturates at 2^COUNT_W−1 and never wraps.
- While out_valid=0, decode fields still reflect id_instr. Downstream qualifies them with out_valid.

## Timing
- Latency: an instruction accepted in cycle N appears with out_valid in cycle N+1, if there is no hazard or flush.
- Throughput: one instruction per cycle when out_ready=1 and there is no hazard.
- Load-use stall: hazard holds the ID register for at least one cycle. The bubble (out_valid=0) leaves the stage and in_ready=0. The stall releases in the first cycle ex_mem_read or the register match drops.
- Backpressure: out_ready=0 holds the ID register. in_ready=0 if id_valid.
- flush takes effect the same cycle (out_valid=0) and id_valid=0 from the next cycle. flush overrides hazard and in_valid.
- Reset outputs: out_valid=0, in_ready=1, hazard=0, stall_cycles=0, pc_out=0. All decode fields are 0, and is_r=1 (instr 0).
- Reset mid-stall: the next cycle is idle with the counter cleared.

## Test plan
- Basic decode: accept 0x010B5020 (add $10,$8,$11) at pc 0x40. Next cycle requires out_valid=1, opcode=0, rs=8, rt=11, rd=10, shamt=0, funct=0x20, is_r=1, pc_out=0x40.
- Immediates: addi with imm 0xFFFF gives imm_ext=0xFFFFFFFF, is_i=1. ori with 0xFFFF gives imm_ext=0x0000FFFF. j 0x0123456 gives jump_addr=0x0123456, is_j=1.
- Load-use: 0x8D280000 (lw $8,0($9)) is followed by 0x010B5020. With ex_mem_read=1 and ex_rt=8, require hazard=1, out_valid=0, in_ready=0 for one cycle, and stall_cycles=1. The add then issues. With ex_rt=0 or ex_rt=12 there is no stall.
- Flush: assert flush while the add is held and in_valid=1. Require out_valid=0 that cycle, id_valid=0 next cycle, and the incoming instruction never issued.
- Backpressure: hold out_ready=0 for 3 cycles with the ID register full. Require a stable output, in_ready=0, and no loss or duplication after release.
- Saturation/reset: with COUNT_W=2, force 5 hazard cycles; stall_cycles=3. Assert rst mid-stall; next cycle out_valid=0 and stall_cycles=0.

Source files
------------

// File: rtl/id_decode_stage.sv
// rtl/id_decode_stage.sv - IF/ID register with MIPS field decode, load-use stall and flush
module id_decode_stage #(
  parameter int INSTR_W = 32,
  parameter int DATA_W  = 32,
  parameter int REG_AW  = 5,
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [INSTR_W-1:0] in_pc,
  input  logic               flush,
  input  logic               ex_mem_read,
  input  logic [REG_AW-1:0]  ex_rt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [5:0]         opcode,
  output logic [REG_AW-1:0]  rs,
  output logic [REG_AW-1:0]  rt,
  output logic [REG_AW-1:0]  rd,
  output logic [REG_AW-1:0]  shamt,
  output logic [5:0]         funct,
  output logic [DATA_W-1:0]  imm_ext,
  output logic [25:0]        jump_addr,
  output logic [INSTR_W-1:0] pc_out,
  output logic               is_r,
  output logic               is_i,
  output logic               is_j,
  output logic               hazard,
  output logic [COUNT_W-1:0] stall_cycles
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [COUNT_W-1:0] CNT_MAX = {COUNT_W{1'b1}};

  logic               id_valid;
  logic [INSTR_W-1:0] id_instr;
  logic [INSTR_W-1:0] id_pc;
  logic [COUNT_W-1:0] stall_cnt;

  logic        zero_ext;
  logic        uses_rs;
  logic        uses_rt;
  logic [15:0] imm16;

  // Field extraction: decode is purely combinational from the held instruction
  always_comb begin
    opcode    = id_instr[31:26];
    rs        = id_instr[25:21];
    rt        = id_instr[20:16];
    rd        = id_instr[15:11];
    shamt     = id_instr[10:6];
    funct     = id_instr[5:0];
    jump_addr = id_instr[25:0];
    imm16     = id_instr[15:0];
    pc_out    = id_pc;
  end

  always_comb begin
    is_r = (opcode == OP_RTYPE);
    is_j = (opcode == OP_J) || (opcode == OP_JAL);
    is_i = !is_r && !is_j;
  end

  always_comb begin
    zero_ext = (opcode == OP_ANDI) || (opcode == OP_ORI) || (opcode == OP_XORI);
    if (zero_ext)
      imm_ext = {{(DATA_W-16){1'b0}}, imm16};
    else
      imm_ext = {{(DATA_W-16){imm16[15]}}, imm16};
  end

  // rt is a source only for R-type, branches and stores; loads and ALU-imm write it
  always_comb begin
    uses_rs = id_valid && !is_j;
    uses_rt = id_valid && (is_r || (opcode == OP_BEQ) || (opcode == OP_BNE) || (opcode == OP_SW));
    hazard  = ex_mem_read && (ex_rt != '0) &&
              ((uses_rs && (rs == ex_rt)) || (uses_rt && (rt == ex_rt)));
  end

  always_comb begin
    out_valid    = id_valid && !hazard && !flush;
    in_ready     = !id_valid || flush || (out_ready && !hazard);
    stall_cycles = stall_cnt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      id_valid <= 1'b0;
      id_instr <= '0;
      id_pc    <= '0;
    end else if (flush) begin
      id_valid <= 1'b0;
    end else if (in_valid && in_ready) begin
      id_valid <= 1'b1;
      id_instr <= in_instr;
      id_pc    <= in_pc;
    end else if (out_valid && out_ready) begin
      id_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      stall_cnt <= '0;
    else if (hazard && !flush && (stall_cnt != CNT_MAX))
      stall_cnt <= stall_cnt + 1'b1;
  end

endmodule

// File: tb/tb_id_decode_stage.sv
// tb/tb_id_decode_stage.sv - scoreboard bench for id_decode_stage
module tb_id_decode_stage;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [5:0]  fn;
    logic [31:0] imm;
    logic [25:0] ja;
    logic [2:0]  cls;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        flush;
  logic        ex_mem_read;
  logic [4:0]  ex_rt;
  logic        out_valid;
  logic        out_ready;
  logic [5:0]  opcode;
  logic [4:0]  rs, rt, rd, shamt;
  logic [5:0]  funct;
  logic [31:0] imm_ext;
  logic [25:0] jump_addr;
  logic [31:0] pc_out;
  logic        is_r, is_i, is_j;
  logic        hazard;
  logic [1:0]  stall_cycles;

  int tests_run = 0;
  int tests_failed = 0;
  int pushed = 0;
  int popped = 0;
  exp_t exp_q[$];
  exp_t v_add, v_addi, v_ori, v_j, v_lw;

  id_decode_stage #(.INSTR_W(32), .DATA_W(32), .REG_AW(5), .COUNT_W(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
    .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
    .out_valid(out_valid), .out_ready(out_ready),
    .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct),
    .imm_ext(imm_ext), .jump_addr(jump_addr), .pc_out(pc_out),
    .is_r(is_r), .is_i(is_i), .is_j(is_j),
    .hazard(hazard), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] instr, input logic [5:0] op, input logic [4:0] rs_e,
                              input logic [4:0] rt_e, input logic [4:0] rd_e, input logic [5:0] fn,
                              input logic [31:0] imm, input logic [25:0] ja, input logic [2:0] cls);
    exp_t e;
    e.instr = instr; e.pc = '0; e.op = op; e.rs = rs_e; e.rt = rt_e; e.rd = rd_e;
    e.fn = fn; e.imm = imm; e.ja = ja; e.cls = cls;
    return e;
  endfunction

  // Monitor: a transfer happens at the coming edge whenever out_valid & out_ready
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_issue_pc", pc_out, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        popped++;
        check("pc_out", pc_out, e.pc);
        check("opcode", {26'd0, opcode}, {26'd0, e.op});
        check("rs", {27'd0, rs}, {27'd0, e.rs});
        check("rt", {27'd0, rt}, {27'd0, e.rt});
        check("rd", {27'd0, rd}, {27'd0, e.rd});
        check("funct", {26'd0, funct}, {26'd0, e.fn});
        check("imm_ext", imm_ext, e.imm);
        check("jump_addr", {6'd0, jump_addr}, {6'd0, e.ja});
        check("class_rij", {29'd0, is_r, is_i, is_j}, {29'd0, e.cls});
      end
    end
  end

  task automatic send(input exp_t v, input logic [31:0] pc);
    bit done = 0;
    in_valid = 1'b1;
    in_instr = v.instr;
    in_pc    = pc;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (in_ready && !flush) begin
        exp_t e;
        e = v;
        e.pc = pc;
        exp_q.push_back(e);
        pushed++;
        done = 1;
      end
      @(posedge clk); #1;
    end
    if (!done) check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    v_add  = mk(32'h010B5020, 6'h00, 5'd8, 5'd11, 5'd10, 6'h20, 32'h0000_5020, 26'h10B5020, 3'b100);
    v_addi = mk(32'h2108FFFF, 6'h08, 5'd8, 5'd8,  5'd31, 6'h3F, 32'hFFFF_FFFF, 26'h108FFFF, 3'b010);
    v_ori  = mk(32'h3508FFFF, 6'h0D, 5'd8, 5'd8,  5'd31, 6'h3F, 32'h0000_FFFF, 26'h108FFFF, 3'b010);
    v_j    = mk(32'h08123456, 6'h02, 5'd0, 5'd18, 5'd6,  6'h16, 32'h0000_3456, 26'h0123456, 3'b001);
    v_lw   = mk(32'h8D280000, 6'h23, 5'd9, 5'd8,  5'd0,  6'h00, 32'h0000_0000, 26'h1280000, 3'b010);

    rst = 1'b1; in_valid = 0; in_instr = 0; in_pc = 0; flush = 0;
    ex_mem_read = 0; ex_rt = 0; out_ready = 1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_hazard", {31'd0, hazard}, 32'd0);
    check("rst_stall", {30'd0, stall_cycles}, 32'd0);
    check("rst_pc_out", pc_out, 32'd0);
    check("rst_fields", {opcode, rs, rt, rd, shamt, funct}, 32'd0);
    check("rst_class", {29'd0, is_r, is_i, is_j}, 32'd4);
    @(posedge clk); #1;

    // Back-to-back decode of each instruction class
    send(v_add, 32'h40);
    send(v_addi, 32'h44);
    send(v_ori, 32'h48);
    send(v_j, 32'h4C);
    idle(2);

    // Load-use: lw leaves, add is captured, then lw sits in EX targeting $8
    send(v_lw, 32'h60);
    send(v_add, 32'h64);
    in_valid = 1'b0; ex_mem_read = 1'b1; ex_rt = 5'd8;
    @(negedge clk);
    check("lu_hazard", {31'd0, hazard}, 32'd1);
    check("lu_out_valid", {31'd0, out_valid}, 32'd0);
    check("lu_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    ex_mem_read = 1'b0;
    @(negedge clk);
    check("lu_release_hazard", {31'd0, hazard}, 32'd0);
    check("lu_release_valid", {31'd0, out_valid}, 32'd1);
    check("lu_stall_count", {30'd0, stall_cycles}, 32'd1);
    @(posedge clk); #1;

    // Loads targeting $0 or an unrelated register never stall
    ex_mem_read = 1'b1; ex_rt = 5'd0;
    send(v_add, 32'h70);
    in_valid = 1'b0;
    @(negedge clk);
    check("rt0_no_hazard", {31'd0, hazard}, 32'd0);
    @(posedge clk); #1;
    ex_rt = 5'd12;
    send(v_add, 32'h74);
    in_valid = 1'b0;
    @(negedge clk);
    check("rt12_no_hazard", {31'd0, hazard}, 32'd0);
    check("rt12_stall_count", {30'd0, stall_cycles}, 32'd1);
    @(posedge clk); #1;
    ex_mem_read = 1'b0;
    idle(1);

    // Flush while add held and another instruction is offered
    out_ready = 1'b0;
    send(v_add, 32'h80);
    in_valid = 1'b1; in_instr = v_addi.instr; in_pc = 32'h84; flush = 1'b1;
    ex_mem_read = 1'b1; ex_rt = 5'd8;
    @(negedge clk);
    check("flush_out_valid", {31'd0, out_valid}, 32'd0);
    check("flush_in_ready", {31'd0, in_ready}, 32'd1);
    void'(exp_q.pop_back());
    pushed--;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; ex_mem_read = 1'b0;
    @(negedge clk);
    check("post_flush_out_valid", {31'd0, out_valid}, 32'd0);
    check("post_flush_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;

    // Backpressure: ori held for 3 cycles while j waits at the input
    out_ready = 1'b0;
    send(v_ori, 32'hC0);
    in_valid = 1'b1; in_instr = v_j.instr; in_pc = 32'hC4;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_out_valid", {31'd0, out_valid}, 32'd1);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      check("bp_pc_out", pc_out, 32'hC0);
      check("bp_imm", imm_ext, 32'h0000_FFFF);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    send(v_j, 32'hC4);
    idle(3);

    // Saturation: 5 hazard cycles on a 2-bit counter already at 1
    send(v_add, 32'hE0);
    in_valid = 1'b0; ex_mem_read = 1'b1; ex_rt = 5'd11;
    repeat (5) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("sat_stall", {30'd0, stall_cycles}, 32'd3);
    check("sat_hazard", {31'd0, hazard}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    void'(exp_q.pop_back());
    pushed--;
    @(posedge clk); #1;
    rst = 1'b0; ex_mem_read = 1'b0;
    @(negedge clk);
    check("rst_mid_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_mid_stall", {30'd0, stall_cycles}, 32'd0);
    check("rst_mid_hazard", {31'd0, hazard}, 32'd0);
    idle(2);

    check("queue_empty", exp_q.size(), 32'd0);
    check("issued_count", popped, pushed);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
